id_stage: RTL
=============

# id_stage

Instruction-decode stage of the five-stage ARM pipeline, including its ID/EXE pipeline register. It consumes the instruction and PC+4 produced by the fetch stage through the IF/ID register. It decodes the data-processing, memory and branch classes and evaluates the condition field against the status register. It holds the 15-entry general register file, written by the write-back stage, and presents registered operands and control to the execute stage one cycle later.

## Interface
- `NUM_REGS`, 15: architectural registers R0–R14. R15 is never read from the file.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `Instruction`  in  32  instruction from the IF/ID register.
- `PC_in`  in  32  PC+4 from the IF/ID register.
- `SR`  in  4  status flags {N,Z,C,V}.
- `hazard`  in  1  hazard unit requests a bubble.
- `flush`  in  1  branch taken in EXE; squash this stage.
- `WB_WB_EN`  in  1  write-back enable.
- `WB_Dest`  in  4  write-back register index.
- `WB_Value`  in  32  write-back data.
- `src1`, `src2`  out  4  combinational source indices, for the hazard unit.
- `Two_src`  out  1  combinational; high when the second source is a register.
- `WB_EN`, `MEM_R_EN`, `MEM_W_EN`, `B`, `S`  out  1 each  registered control.
- `EXE_CMD`  out  4  registered ALU command.
- `Val_Rn`, `Val_Rm`, `PC`  out  32 each  registered operands and PC.
- `imm`  out  1  registered immediate flag (instruction bit 25).
- `Shift_operand`  out  12  registered.
- `Signed_imm_24`  out  24  registered.
- `Dest`  out  4  registered destination (Rd).

## Operation
- **Instruction fields:**
  - cond[31:28], mode[27:26], I[25], opcode[24:21], S[20]
  - Rn[19:16], Rd[15:12], shift_operand[11:0], Rm[3:0], signed_imm_24[23:0]
- **Mode 00, data processing.** Opcode maps to EXE_CMD as follows; WB_EN=1 unless noted:
  - MOV 1101→0001, MVN 1111→1001
  - ADD 0100→0010, ADC 0101→0011
  - SUB 0010→0100, SBC 0110→0101
  - AND 0000→0110, ORR 1100→0111, EOR 0001→1000
  - CMP 1010→0100 and TST 1000→0110, both with WB_EN=0
  - Any other opcode → all control outputs 0.
  - S passes through.
- **Mode 01, memory.**
  - S=1 is LDR: MEM_R_EN=1, WB_EN=1.
  - S=0 is STR: MEM_W_EN=1.
  - EXE_CMD=0010 for both.
  - Output S=0.
- **Mode 10, branch.** B=1, all other control 0.
- **Mode 11.** All control 0.
- **Condition codes:**
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V)
  - AL 1; 1111 evaluates false.
  - A false condition zeroes WB_EN, MEM_R_EN, MEM_W_EN, B, S and EXE_CMD.
- **Register file.**
  - Read ports are addressed by Rn and by src2.
  - src2 = Rd when the instruction is a store (mode 01, S=0); otherwise src2 = Rm.
  - Write is on the clock edge when WB_WB_EN=1.
  - Same-cycle write/read bypass: if WB_WB_EN=1 and WB_Dest matches a read address, that port returns WB_Value.
  - WB_Dest=15 is ignored.
- **Sources.** src1=Rn. Two_src = !I | (mode 01 & S=0).

## Timing
- Latency is 1 cycle: decode of the instruction at edge k appears on the registered outputs after edge k+1.
- **Reset**, priority highest:
  - All registered outputs become 0.
  - Ri loads the value i, for i = 0..14.
- **flush**, priority 2: on the next edge all registered control (WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD) is cleared. Datapath registers may load normally.
- **hazard**, priority 3: same clearing as flush (bubble insertion). The IF stage freezes separately.
- **flush and hazard together:** behave as flush.
- **Register-file write during reset:** the write is ignored.
- src1, src2 and Two_src are combinational from Instruction and are valid the same cycle.

## Structure
- Shared package `arm_defs` holds:
  - EXE_CMD constants, mode constants and condition-code constants
  - ARM opcode constants
- Sub-modules:
  - `register_file`: storage, reset init and bypass.
  - `condition_check`: combinational.
- The control decode and the ID/EXE register stay in this module.

## Test plan
- **Reset then ADD.** Reset, then feed 0xE0821003 (ADD R1,R2,R3), SR=0 → next edge: EXE_CMD=0010, WB_EN=1, Val_Rn=2, Val_Rm=3, Dest=1, Two_src=1.
- **LDR.** Feed 0xE5910004 (LDR R0,[R1,#4]) → MEM_R_EN=1, WB_EN=1, EXE_CMD=0010, S=0, Val_Rn=1, Shift_operand=0x004.
- **Condition fail and pass.** Feed 0x00821003 (ADDEQ) with SR=0000 → all control 0. Repeat with SR=0100 → WB_EN=1.
- **Branch.** Feed 0xEAFFFFFE → B=1, Signed_imm_24=0xFFFFFE, PC=PC_in.
- **Write-back bypass.** WB_WB_EN=1, WB_Dest=2, WB_Value=0xDEADBEEF while the ADD above decodes → Val_Rn=0xDEADBEEF. The next read of R2 also returns 0xDEADBEEF.
- **Hazard and flush.** hazard=1 with the ADD → control 0 next cycle. flush=1 and hazard=1 together → control 0. rst asserted mid-stream → outputs 0 and R5 reads 5.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared ARM decode definitions: widths, EXE_CMD encodings, instruction modes,
// condition codes, data-processing opcodes and the ID/EXE control payload.
package arm_defs;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned NUM_REGS   = 15;
  localparam int unsigned CMD_W      = 4;
  localparam int unsigned SR_W       = 4;

  // ALU commands presented to the execute stage
  localparam logic [CMD_W-1:0] CMD_NOP = 4'b0000;
  localparam logic [CMD_W-1:0] CMD_MOV = 4'b0001;
  localparam logic [CMD_W-1:0] CMD_ADD = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_ADC = 4'b0011;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_SBC = 4'b0101;
  localparam logic [CMD_W-1:0] CMD_AND = 4'b0110;
  localparam logic [CMD_W-1:0] CMD_ORR = 4'b0111;
  localparam logic [CMD_W-1:0] CMD_EOR = 4'b1000;
  localparam logic [CMD_W-1:0] CMD_MVN = 4'b1001;

  // Instruction class, bits [27:26]
  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  // Condition field, bits [31:28]
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Data-processing opcodes, bits [24:21]
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // Control bundle carried across the ID/EXE register
  typedef struct packed {
    logic             wb_en;
    logic             mem_r_en;
    logic             mem_w_en;
    logic             b;
    logic             s;
    logic [CMD_W-1:0] exe_cmd;
  } ctrl_t;

endpackage

// File: rtl/id_stage_condition_check.sv
// Evaluates an ARM condition field against the status flags.
//   cond      : condition field of the instruction
//   sr        : status flags {N,Z,C,V}
//   cond_ok_c : combinational, high when the instruction should execute
module condition_check
  import arm_defs::*;
(
  input  logic [3:0]      cond,
  input  logic [SR_W-1:0] sr,
  output logic            cond_ok_c
);

  logic n, z, c, v;
  assign {n, z, c, v} = sr;

  // Flag predicate per condition; 1111 is treated as never
  always_comb begin
    cond_ok_c = 1'b0;
    case (cond)
      COND_EQ: cond_ok_c = z;
      COND_NE: cond_ok_c = !z;
      COND_CS: cond_ok_c = c;
      COND_CC: cond_ok_c = !c;
      COND_MI: cond_ok_c = n;
      COND_PL: cond_ok_c = !n;
      COND_VS: cond_ok_c = v;
      COND_VC: cond_ok_c = !v;
      COND_HI: cond_ok_c = c && !z;
      COND_LS: cond_ok_c = !c || z;
      COND_GE: cond_ok_c = (n == v);
      COND_LT: cond_ok_c = (n != v);
      COND_GT: cond_ok_c = !z && (n == v);
      COND_LE: cond_ok_c = z || (n != v);
      COND_AL: cond_ok_c = 1'b1;
      default: cond_ok_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_stage_register_file.sv
// 15-entry general register file with two read ports and write-to-read bypass.
//   clk, rst             : clock, synchronous active-high reset (Ri <= i)
//   rd_addr1/2           : read addresses; address 15 reads as zero
//   rd_data1_c/2_c       : combinational read data
//   wr_en/wr_addr/wr_data: write port, address 15 ignored, ignored in reset
module register_file
  import arm_defs::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rd_addr1,
  input  logic [REG_ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0]     rd_data1_c,
  output logic [DATA_W-1:0]     rd_data2_c,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data
);

  localparam logic [REG_ADDR_W-1:0] PC_ADDR = REG_ADDR_W'(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_valid;

  assign wr_valid = wr_en && (wr_addr != PC_ADDR);

  // Storage; reset preloads each register with its own index
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= DATA_W'(i);
      end
    end else if (wr_valid) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read with same-cycle bypass of the write-back value
  function automatic logic [DATA_W-1:0] read_port(input logic [REG_ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = '0;
    if (addr == PC_ADDR) val = '0;
    else if (wr_valid && (wr_addr == addr)) val = wr_data;
    else val = regs[addr];
    return val;
  endfunction

  always_comb rd_data1_c = read_port(rd_addr1);
  always_comb rd_data2_c = read_port(rd_addr2);

endmodule

// File: rtl/id_stage.sv
// ARM instruction-decode stage with its ID/EXE pipeline register.
//   Inputs : clk, rst (sync active-high), Instruction, PC_in, SR {N,Z,C,V},
//            hazard/flush (bubble requests), WB_WB_EN/WB_Dest/WB_Value.
//   Comb   : src1, src2, Two_src for the hazard unit.
//   Regs   : WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD, Val_Rn, Val_Rm, PC,
//            imm, Shift_operand, Signed_imm_24, Dest.
module id_stage
  import arm_defs::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     Instruction,
  input  logic [DATA_W-1:0]     PC_in,
  input  logic [SR_W-1:0]       SR,
  input  logic                  hazard,
  input  logic                  flush,
  input  logic                  WB_WB_EN,
  input  logic [REG_ADDR_W-1:0] WB_Dest,
  input  logic [DATA_W-1:0]     WB_Value,
  output logic [REG_ADDR_W-1:0] src1,
  output logic [REG_ADDR_W-1:0] src2,
  output logic                  Two_src,
  output logic                  WB_EN,
  output logic                  MEM_R_EN,
  output logic                  MEM_W_EN,
  output logic                  B,
  output logic                  S,
  output logic [CMD_W-1:0]      EXE_CMD,
  output logic [DATA_W-1:0]     Val_Rn,
  output logic [DATA_W-1:0]     Val_Rm,
  output logic [DATA_W-1:0]     PC,
  output logic                  imm,
  output logic [11:0]           Shift_operand,
  output logic [23:0]           Signed_imm_24,
  output logic [REG_ADDR_W-1:0] Dest
);

  logic [3:0]            cond;
  logic [1:0]            mode;
  logic                  i_bit;
  logic [3:0]            opcode;
  logic                  s_bit;
  logic [REG_ADDR_W-1:0] rn, rd, rm;
  logic                  is_store;

  assign cond   = Instruction[31:28];
  assign mode   = Instruction[27:26];
  assign i_bit  = Instruction[25];
  assign opcode = Instruction[24:21];
  assign s_bit  = Instruction[20];
  assign rn     = Instruction[19:16];
  assign rd     = Instruction[15:12];
  assign rm     = Instruction[3:0];

  // Stores read Rd as the data operand through the second port
  assign is_store = (mode == MODE_MEM) && !s_bit;
  assign src1     = rn;
  assign src2     = is_store ? rd : rm;
  assign Two_src  = !i_bit || is_store;

  logic              cond_ok_c;
  logic [DATA_W-1:0] rn_val_c, rm_val_c;

  condition_check u_cond (
    .cond      (cond),
    .sr        (SR),
    .cond_ok_c (cond_ok_c)
  );

  register_file u_rf (
    .clk        (clk),
    .rst        (rst),
    .rd_addr1   (rn),
    .rd_addr2   (src2),
    .rd_data1_c (rn_val_c),
    .rd_data2_c (rm_val_c),
    .wr_en      (WB_WB_EN),
    .wr_addr    (WB_Dest),
    .wr_data    (WB_Value)
  );

  ctrl_t dec_c, ctrl_d, ctrl_q;
  logic  dp_ok_c;

  // Control decode by instruction class
  always_comb begin
    dec_c   = '0;
    dp_ok_c = 1'b1;
    case (mode)
      MODE_DP: begin
        case (opcode)
          OP_MOV:  begin dec_c.exe_cmd = CMD_MOV; dec_c.wb_en = 1'b1; end
          OP_MVN:  begin dec_c.exe_cmd = CMD_MVN; dec_c.wb_en = 1'b1; end
          OP_ADD:  begin dec_c.exe_cmd = CMD_ADD; dec_c.wb_en = 1'b1; end
          OP_ADC:  begin dec_c.exe_cmd = CMD_ADC; dec_c.wb_en = 1'b1; end
          OP_SUB:  begin dec_c.exe_cmd = CMD_SUB; dec_c.wb_en = 1'b1; end
          OP_SBC:  begin dec_c.exe_cmd = CMD_SBC; dec_c.wb_en = 1'b1; end
          OP_AND:  begin dec_c.exe_cmd = CMD_AND; dec_c.wb_en = 1'b1; end
          OP_ORR:  begin dec_c.exe_cmd = CMD_ORR; dec_c.wb_en = 1'b1; end
          OP_EOR:  begin dec_c.exe_cmd = CMD_EOR; dec_c.wb_en = 1'b1; end
          OP_CMP:  dec_c.exe_cmd = CMD_SUB;
          OP_TST:  dec_c.exe_cmd = CMD_AND;
          default: dp_ok_c = 1'b0;
        endcase
        dec_c.s = s_bit && dp_ok_c;
      end
      MODE_MEM: begin
        dec_c.exe_cmd  = CMD_ADD;
        dec_c.mem_r_en = s_bit;
        dec_c.wb_en    = s_bit;
        dec_c.mem_w_en = !s_bit;
      end
      MODE_BR: dec_c.b = 1'b1;
      default: dec_c = '0;
    endcase
  end

  // Failed condition, flush or hazard turn the slot into a bubble
  always_comb begin
    ctrl_d = '0;
    if (cond_ok_c && !flush && !hazard) ctrl_d = dec_c;
  end

  // ID/EXE register
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q        <= '0;
      Val_Rn        <= '0;
      Val_Rm        <= '0;
      PC            <= '0;
      imm           <= 1'b0;
      Shift_operand <= '0;
      Signed_imm_24 <= '0;
      Dest          <= '0;
    end else begin
      ctrl_q        <= ctrl_d;
      Val_Rn        <= rn_val_c;
      Val_Rm        <= rm_val_c;
      PC            <= PC_in;
      imm           <= i_bit;
      Shift_operand <= Instruction[11:0];
      Signed_imm_24 <= Instruction[23:0];
      Dest          <= rd;
    end
  end

  assign WB_EN    = ctrl_q.wb_en;
  assign MEM_R_EN = ctrl_q.mem_r_en;
  assign MEM_W_EN = ctrl_q.mem_w_en;
  assign B        = ctrl_q.b;
  assign S        = ctrl_q.s;
  assign EXE_CMD  = ctrl_q.exe_cmd;

endmodule
